adder_accum: RTL and testbench
==============================

# adder_accum

Parametrised multi-lane signed accumulating adder for the reduction datapath. It sums a variable-length group of input vectors lane-by-lane, delimited by `in_last`, and presents one registered result vector per group. It uses valid/ready handshakes on both sides, a per-lane overflow flag and a beat count. It sits between the adder-switch tree outputs and the result writeback, replacing single-cycle fixed 32-bit registered adders where partial sums arrive over several cycles.

## Interface
Parameters:
- `DATA_W`, 32, width of one signed lane operand and result.
- `LANES`, 4, number of independent lanes.
- `CNT_W`, 8, width of the beat counter.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  block can accept a beat this cycle.
- `in_data`  in  LANES*DATA_W  lane i is at bits [i*DATA_W +: DATA_W], two's complement.
- `in_last`  in  1  accepted beat closes the current group.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  LANES*DATA_W  per-lane group sums.
- `out_count`  out  CNT_W  beats in the group, saturating at 2^CNT_W-1.
- `out_ovf`  out  LANES  per-lane sticky signed overflow seen in the group.

## Operation
- A beat is accepted when `in_valid && in_ready`. A result is consumed when `out_valid && out_ready`.
- States:
  - ACC: accumulating; reset state.
  - HOLD: result registered, waiting for `out_ready`.
- `in_ready` = (state==ACC) || (state==HOLD && out_ready). It is combinational and forced to 0 while `rst` is high.
- An internal `first` flag is set at reset and after every accepted `in_last`. It is cleared on any other accepted beat.
- On an accepted beat, per lane: base = first ? 0 : acc[i]; sum = base + in_data[i]. The sum is computed in DATA_W+1 bits.
- Signed overflow, per lane: the operands have equal signs and the result sign differs. ovf[i] <= (first ? 0 : ovf[i]) | overflow.
- Count: cnt <= first ? 1 : min(cnt+1, 2^CNT_W-1).
- Accepted beat with `in_last`:
  - `out_data`, `out_count` and `out_ovf` load the final values.
  - `out_valid` <= 1 and the state moves to HOLD.
- Accepted beat without `in_last`: internal registers update; the state stays ACC.
- HOLD with `out_ready` and no accepted beat: `out_valid` <= 0 and the state moves to ACC.
- HOLD with `out_ready` and an accepted beat, in the same cycle:
  - The old result is consumed.
  - The new beat starts a fresh group, because `first` is set.
  - With `in_last`, the state stays HOLD and the new result is loaded, with `out_valid` held at 1.
  - Without `in_last`, the state moves to ACC.
- HOLD without `out_ready`: all outputs stay stable and no input is accepted.
- Result format: the output registers hold the last result until overwritten. Downstream must use them only while `out_valid` is high.

## Timing
- Reset values:
  - `out_valid`, `out_data`, `out_count` and `out_ovf` = 0.
  - State = ACC, `first` = 1, internal accumulators = 0.
- Reset asserted mid-group or in HOLD clears all state immediately. The partial group is discarded.
- Latency: `out_valid` rises on the edge that accepts the `in_last` beat, so the result is visible on the next cycle.
- Throughput:
  - One beat per cycle while in ACC.
  - Single-beat groups sustain one result per cycle when `out_ready` is held high.
  - A multi-beat group does not overlap with a held result; its beats are accepted only after the previous result is consumed.
- `out_valid` never drops without a consume. `out_data`, `out_count` and `out_ovf` are stable while `out_valid && !out_ready`.
- `in_valid` deasserted mid-group simply pauses accumulation; there is no timeout.

## Configuration
- `ADDER_ACCUM_SAT_EN` defined:
  - On overflow, each lane clamps to 2^(DATA_W-1)-1 (positive overflow) or -2^(DATA_W-1) (negative overflow).
  - Later beats accumulate from the clamped value.
  - `out_ovf` is still set.
- `ADDER_ACCUM_SAT_EN` undefined:
  - Two's-complement wrap-around.
  - `out_ovf` still reports overflow.

## Test plan
- Reset: assert `rst` with `in_valid`=1 -> `in_ready`=0 and all outputs 0. After release, `in_ready`=1.
- Three-beat group, lane0 = 5, -2, 10 with `in_last` on beat 3 and `out_ready`=1 -> one cycle with `out_valid`=1, lane0=13, `out_count`=3, `out_ovf`=0.
- Back-to-back single-beat groups, lane1 = 7 then 9, `out_ready`=1 -> `out_valid` stays high for two consecutive cycles with lane1 = 7 then 9, and `in_ready` stays 1.
- Backpressure: `out_ready`=0 for 4 cycles after a result -> `in_ready`=0 and outputs stable. With `out_ready`=1, the result is consumed and the next group's `first` beat starts from 0.
- Overflow, lane2 = 0x7FFFFFFF + 1:
  - SAT_EN undefined -> 0x80000000 with `out_ovf`[2]=1.
  - SAT_EN defined -> 0x7FFFFFFF with `out_ovf`[2]=1.
- Count saturation with CNT_W=2: a 6-beat group -> `out_count`=3.

Source files
------------

// File: rtl/adder_accum.sv
// -----------------------------------------------------------------------------
// adder_accum -- multi-lane signed accumulating adder for the reduction path.
//
// Sums a variable-length group of input vectors lane by lane. A group ends on
// an accepted beat with in_last set. One registered result vector is presented
// per group. Both sides use valid/ready handshakes.
//
// Parameters: DATA_W (lane width), LANES (lane count), CNT_W (beat counter width)
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        input beat handshake (in_ready is combinational)
//   in_data, in_last         LANES packed signed operands, group delimiter
//   out_valid/out_ready      result handshake
//   out_data                 per-lane group sums
//   out_count                beats in the group, saturating at 2^CNT_W-1
//   out_ovf                  per-lane sticky signed overflow for the group
//
// Optional feature: define ADDER_ACCUM_SAT_EN to clamp each lane on overflow
// instead of wrapping. out_ovf reports overflow in both builds.
// -----------------------------------------------------------------------------

// One lane: accumulator, sticky overflow and the lane's result registers.
module adder_accum_lane #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              beat,     // accepted input beat
    input  logic              last,     // the beat closes the group
    input  logic              first,    // the beat opens a group
    input  logic [DATA_W-1:0] in_lane,
    output logic [DATA_W-1:0] out_lane,
    output logic              out_ovf
);
    logic [DATA_W-1:0] acc;
    logic              ovf_r;
    logic [DATA_W-1:0] base;
    logic [DATA_W:0]   sum_ext;
    logic              ovf_now;
    logic [DATA_W-1:0] nxt_acc;
    logic              nxt_ovf;

    assign base    = first ? '0 : acc;
    assign sum_ext = {base[DATA_W-1], base} + {in_lane[DATA_W-1], in_lane};
    // With sign-extended operands the top two sum bits disagree exactly when
    // the operands share a sign and the DATA_W-bit result sign differs.
    assign ovf_now = sum_ext[DATA_W] ^ sum_ext[DATA_W-1];
    assign nxt_ovf = (first ? 1'b0 : ovf_r) | ovf_now;

`ifdef ADDER_ACCUM_SAT_EN
    localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    // On overflow the true sign is carried in the extension bit.
    assign nxt_acc = !ovf_now      ? sum_ext[DATA_W-1:0] :
                     sum_ext[DATA_W] ? MIN_NEG : MAX_POS;
`else
    assign nxt_acc = sum_ext[DATA_W-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            ovf_r    <= 1'b0;
            out_lane <= '0;
            out_ovf  <= 1'b0;
        end else if (beat) begin
            acc   <= nxt_acc;
            ovf_r <= nxt_ovf;
            if (last) begin
                out_lane <= nxt_acc;
                out_ovf  <= nxt_ovf;
            end
        end
    end
endmodule

module adder_accum #(
    parameter int DATA_W = 32,
    parameter int LANES  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]        out_count,
    output logic [LANES-1:0]        out_ovf
);
    typedef enum logic {ACC, HOLD} state_t;

    state_t                        state;
    logic                          first;
    logic [CNT_W-1:0]              cnt;
    logic [CNT_W-1:0]              nxt_cnt;
    logic                          beat;
    logic [LANES-1:0][DATA_W-1:0]  in_lanes;
    logic [LANES-1:0][DATA_W-1:0]  out_lanes;

    // HOLD can take a new beat in the same cycle its result is consumed.
    assign in_ready = !rst && ((state == ACC) || out_ready);
    assign beat     = in_valid && in_ready;
    assign nxt_cnt  = first ? CNT_W'(1) : ((cnt == '1) ? cnt : cnt + 1'b1);

    assign in_lanes = in_data;
    assign out_data = out_lanes;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        adder_accum_lane #(.DATA_W(DATA_W)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .beat     (beat),
            .last     (in_last),
            .first    (first),
            .in_lane  (in_lanes[i]),
            .out_lane (out_lanes[i]),
            .out_ovf  (out_ovf[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACC;
            first     <= 1'b1;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_count <= '0;
        end else if (beat) begin
            first <= in_last;
            cnt   <= nxt_cnt;
            if (in_last) begin
                out_count <= nxt_cnt;
                out_valid <= 1'b1;
                state     <= HOLD;
            end else if (state == HOLD) begin
                // Old result consumed, new multi-beat group started.
                out_valid <= 1'b0;
                state     <= ACC;
            end
        end else if (state == HOLD && out_ready) begin
            out_valid <= 1'b0;
            state     <= ACC;
        end
    end
endmodule

// File: tb/tb_adder_accum.sv
// Directed bench for adder_accum: reset, grouping, back-to-back results,
// backpressure, overflow (wrap or clamp by build), sticky overflow and
// count saturation on a CNT_W=2 instance sharing the same stimulus.
module tb_adder_accum;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_data = '0;
    logic         in_ready, out_valid;
    logic [127:0] out_data;
    logic [7:0]   out_count;
    logic [3:0]   out_ovf;
    logic         in_ready2, out_valid2;
    logic [127:0] out_data2;
    logic [1:0]   out_count2;
    logic [3:0]   out_ovf2;
    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    adder_accum dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_count(out_count),
        .out_ovf(out_ovf)
    );

    adder_accum #(.CNT_W(2)) dut_c2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid2),
        .out_ready(out_ready), .out_data(out_data2), .out_count(out_count2),
        .out_ovf(out_ovf2)
    );

    function automatic logic [127:0] pack(input logic [31:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [127:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
    endtask

    task automatic test_reset;
        drive(pack(32'd11, 32'd22, 32'd33, 32'd44), 1'b1);
        out_ready = 1'b1;
        tick;
        n_chk++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready); else n_pass++;
        n_chk++; if ({out_valid, out_data, out_count, out_ovf} !== '0)
            $display("FAIL reset_outputs got v=%b d=%h c=%0d o=%b want all 0", out_valid, out_data, out_count, out_ovf);
        else n_pass++;
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL release_in_ready got %b want 1", in_ready); else n_pass++;
        // Partial group interrupted by reset must be discarded.
        drive(pack(32'd50, 0, 0, 0), 1'b0);
        tick;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        drive(pack(32'd4, 0, 0, 0), 1'b1);
        tick;
        n_chk++; if (out_valid !== 1'b1 || out_data[31:0] !== 32'd4 || out_count !== 8'd1)
            $display("FAIL midreset_discard got v=%b l0=%0d c=%0d want v=1 l0=4 c=1", out_valid, out_data[31:0], out_count);
        else n_pass++;
        in_valid = 1'b0;
        tick;
    endtask

    task automatic test_three_beat;
        out_ready = 1'b1;
        drive(pack(32'd5, 0, 0, 0), 1'b0); tick;
        drive(pack(-32'sd2, 0, 0, 0), 1'b0); tick;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL three_mid_valid got %b want 0", out_valid); else n_pass++;
        drive(pack(32'd10, 0, 0, 0), 1'b1); tick;
        in_valid = 1'b0;
        n_chk++; if (out_valid !== 1'b1 || out_data[31:0] !== 32'd13 || out_count !== 8'd3 || out_ovf !== 4'b0)
            $display("FAIL three_result got v=%b l0=%0d c=%0d o=%b want v=1 l0=13 c=3 o=0",
                     out_valid, out_data[31:0], out_count, out_ovf);
        else n_pass++;
        tick;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL three_consumed got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        drive(pack(0, 32'd7, 0, 0), 1'b1);
        #1;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL b2b_ready0 got %b want 1", in_ready); else n_pass++;
        tick;
        n_chk++; if (out_valid !== 1'b1 || out_data[63:32] !== 32'd7 || out_count !== 8'd1)
            $display("FAIL b2b_first got v=%b l1=%0d c=%0d want v=1 l1=7 c=1", out_valid, out_data[63:32], out_count);
        else n_pass++;
        drive(pack(0, 32'd9, 0, 0), 1'b1);
        #1;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL b2b_ready1 got %b want 1", in_ready); else n_pass++;
        tick;
        in_valid = 1'b0;
        n_chk++; if (out_valid !== 1'b1 || out_data[63:32] !== 32'd9 || out_count !== 8'd1)
            $display("FAIL b2b_second got v=%b l1=%0d c=%0d want v=1 l1=9 c=1", out_valid, out_data[63:32], out_count);
        else n_pass++;
        tick;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL b2b_drain got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_backpressure;
        int bad = 0;
        out_ready = 1'b0;
        drive(pack(32'd3, 0, 0, 0), 1'b0); tick;
        drive(pack(32'd4, 0, 0, 0), 1'b1); tick;
        drive(pack(32'd100, 0, 0, 0), 1'b0);
        for (int k = 0; k < 4; k++) begin
            #1;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data[31:0] !== 32'd7 || out_count !== 8'd2) bad++;
            tick;
        end
        n_chk++; if (bad != 0) $display("FAIL bp_stable got %0d bad cycles want 0 (v=%b l0=%0d)", bad, out_valid, out_data[31:0]);
        else n_pass++;
        out_ready = 1'b1;
        #1;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready got %b want 1", in_ready); else n_pass++;
        tick;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL bp_consume got %b want 0", out_valid); else n_pass++;
        drive(pack(32'd1, 0, 0, 0), 1'b1); tick;
        in_valid = 1'b0;
        n_chk++; if (out_valid !== 1'b1 || out_data[31:0] !== 32'd101 || out_count !== 8'd2)
            $display("FAIL bp_fresh_group got v=%b l0=%0d c=%0d want v=1 l0=101 c=2", out_valid, out_data[31:0], out_count);
        else n_pass++;
        tick;
    endtask

    task automatic test_overflow;
        logic [31:0] exp2, exp3;
`ifdef ADDER_ACCUM_SAT_EN
        exp2 = 32'h7FFF_FFFF; exp3 = 32'h8000_0000;
`else
        exp2 = 32'h8000_0000; exp3 = 32'h7FFF_FFFF;
`endif
        out_ready = 1'b1;
        drive(pack(0, 0, 32'h7FFF_FFFF, 32'h8000_0000), 1'b0); tick;
        drive(pack(0, 0, 32'd1, 32'hFFFF_FFFF), 1'b1); tick;
        in_valid = 1'b0;
        n_chk++; if (out_data[95:64] !== exp2) $display("FAIL ovf_pos_lane2 got %h want %h", out_data[95:64], exp2); else n_pass++;
        n_chk++; if (out_data[127:96] !== exp3) $display("FAIL ovf_neg_lane3 got %h want %h", out_data[127:96], exp3); else n_pass++;
        n_chk++; if (out_ovf !== 4'b1100) $display("FAIL ovf_flags got %b want 1100", out_ovf); else n_pass++;
        tick;
    endtask

    task automatic test_sticky;
        logic [31:0] exp0;
`ifdef ADDER_ACCUM_SAT_EN
        exp0 = 32'h7FFF_FFFF;
`else
        exp0 = 32'h8000_0005;
`endif
        out_ready = 1'b1;
        drive(pack(32'h7FFF_FFFF, 0, 0, 0), 1'b0); tick;
        drive(pack(32'd1, 0, 0, 0), 1'b0); tick;
        drive(pack(32'd5, 0, 0, 0), 1'b1); tick;
        in_valid = 1'b0;
        n_chk++; if (out_data[31:0] !== exp0 || out_ovf !== 4'b0001)
            $display("FAIL sticky got l0=%h o=%b want l0=%h o=0001", out_data[31:0], out_ovf, exp0);
        else n_pass++;
        tick;
        // A fresh clean group must not inherit the flag.
        drive(pack(32'd1, 0, 0, 0), 1'b1); tick;
        in_valid = 1'b0;
        n_chk++; if (out_ovf !== 4'b0000 || out_data[31:0] !== 32'd1)
            $display("FAIL sticky_clear got l0=%h o=%b want l0=1 o=0000", out_data[31:0], out_ovf);
        else n_pass++;
        tick;
    endtask

    task automatic test_count_sat;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            drive(pack(32'd1, 0, 0, 0), k == 5);
            tick;
        end
        in_valid = 1'b0;
        n_chk++; if (out_count2 !== 2'd3 || out_valid2 !== 1'b1)
            $display("FAIL count_sat_c2 got c=%0d v=%b want c=3 v=1", out_count2, out_valid2);
        else n_pass++;
        n_chk++; if (out_count !== 8'd6 || out_data[31:0] !== 32'd6)
            $display("FAIL count_wide got c=%0d l0=%0d want c=6 l0=6", out_count, out_data[31:0]);
        else n_pass++;
        tick;
    endtask

    initial begin
        test_reset;
        test_three_beat;
        test_back_to_back;
        test_backpressure;
        test_overflow;
        test_sticky;
        test_count_sat;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
